// File: rtl/pipe_adder_pkg.sv
// Shared helpers and stage record for pipe_adder.
// The sub field exists only when ADDSUB_EN is defined.
package pipe_adder_pkg;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Per-stage control state; partial sum and operand chunks live in
    // width-sized arrays in the top because their size is a module parameter.
    typedef struct packed {
        logic co;
`ifdef ADDSUB_EN
        logic sub;
`endif
    } stage_t;

endpackage

// File: rtl/pipe_adder_chunk_adder.sv
// CW-bit combinational adder slice, one per pipeline stage.
module chunk_adder #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder: one CW-bit chunk per stage, bubble-collapsing valid/ready.
// Optional ADDSUB_EN adds a sub input (x - y - cin as x + ~y + !cin).
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
`ifdef ADDSUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = chunk_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipe_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic [STAGES-1:0] vld_pipe;
    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] inv;
    logic [WIDTH-1:0]  acc [STAGES];  // {x chunks still to add, sum chunks done}
    logic [WIDTH-1:0]  yq  [STAGES];  // y rotated so the next chunk sits in the low bits
    stage_t            st  [STAGES];

    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];
    assign out_valid   = vld_pipe[STAGES-1];
    assign sum         = acc[STAGES-1];
    assign cout        = st[STAGES-1].co;

`ifndef ADDSUB_EN
    assign inv = '0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             pv;
        logic [WIDTH-1:0] acc_src;
        logic [WIDTH-1:0] acc_d;
        logic [CW-1:0]    ych;
        logic [CW-1:0]    a;
        logic [CW-1:0]    b;
        logic [CW-1:0]    s;
        logic             ci;
        logic             co;
        logic             v_q;
        logic [WIDTH-1:0] acc_q;
        stage_t           st_q;

        if (k == 0) begin : g_head
            assign pv      = in_valid;
            assign acc_src = x;
            assign ych     = y[CW-1:0];
            assign ci      = cin ^ inv[0];
`ifdef ADDSUB_EN
            assign inv[0]  = sub;
`endif
        end else begin : g_body
            assign pv      = vld_pipe[k-1];
            assign acc_src = acc[k-1];
            assign ych     = yq[k-1][CW-1:0];
            assign ci      = st[k-1].co;
`ifdef ADDSUB_EN
            assign inv[k]  = st[k-1].sub;
`endif
        end

        assign a = acc_src[k*CW +: CW];
        assign b = ych ^ {CW{inv[k]}};

        chunk_adder #(.CW(CW)) u_add (
            .a  (a),
            .b  (b),
            .ci (ci),
            .s  (s),
            .co (co)
        );

        always_comb begin
            acc_d              = acc_src;
            acc_d[k*CW +: CW]  = s;
        end

        // A stage may take new data when empty or when its own contents move on.
        assign rdy[k] = !v_q || rdy[k+1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                acc_q <= '0;
                st_q  <= '0;
            end else if (rdy[k]) begin
                v_q <= pv;
                if (pv) begin
                    acc_q   <= acc_d;
                    st_q.co <= co;
`ifdef ADDSUB_EN
                    st_q.sub <= inv[k];
`endif
                end
            end
        end

        assign vld_pipe[k] = v_q;
        assign acc[k]      = acc_q;
        assign st[k]       = st_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] yq_q;
            if (k == 0) begin : g_y0
                always_ff @(posedge clk) begin
                    if (rdy[k] && pv)
                        yq_q <= (y >> CW) | (y << (WIDTH - CW));
                end
            end else begin : g_yk
                always_ff @(posedge clk) begin
                    if (rdy[k] && pv)
                        yq_q <= (yq[k-1] >> CW) | (yq[k-1] << (WIDTH - CW));
                end
            end
            assign yq[k] = yq_q;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: 8-bit/2-stage and 32-bit/4-stage instances.
module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready, v8_cin, v8_cout;
    logic [7:0] v8_x, v8_y, v8_sum;
`ifdef ADDSUB_EN
    logic       v8_sub;
    logic       a_sub;
`endif

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cin, a_cout;
    logic [31:0] a_x, a_y, a_sum;

    pipe_adder #(.WIDTH(8), .STAGES(2)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(v8_in_valid), .in_ready(v8_in_ready),
        .x(v8_x), .y(v8_y), .cin(v8_cin),
`ifdef ADDSUB_EN
        .sub(v8_sub),
`endif
        .out_valid(v8_out_valid), .out_ready(v8_out_ready),
        .sum(v8_sum), .cout(v8_cout)
    );

    pipe_adder #(.WIDTH(32), .STAGES(4)) u32 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x(a_x), .y(a_y), .cin(a_cin),
`ifdef ADDSUB_EN
        .sub(a_sub),
`endif
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sum(a_sum), .cout(a_cout)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Hand-computed vectors: {cout,sum} = x + y + cin
    logic [31:0] tx [8];
    logic [31:0] ty [8];
    logic        tc [8];
    logic [32:0] te [8];

    initial begin
        tx[0] = 32'h0000006B; ty[0] = 32'h0000005D; tc[0] = 1'b0; te[0] = 33'h0_000000C8;
        tx[1] = 32'hFFFFFFFF; ty[1] = 32'h00000000; tc[1] = 1'b1; te[1] = 33'h1_00000000;
        tx[2] = 32'h0FFFFFFF; ty[2] = 32'h00000001; tc[2] = 1'b0; te[2] = 33'h0_10000000;
        tx[3] = 32'h80000000; ty[3] = 32'h80000000; tc[3] = 1'b0; te[3] = 33'h1_00000000;
        tx[4] = 32'h12345678; ty[4] = 32'h11111111; tc[4] = 1'b1; te[4] = 33'h0_2345678A;
        tx[5] = 32'h000000FF; ty[5] = 32'h00000001; tc[5] = 1'b0; te[5] = 33'h0_00000100;
        tx[6] = 32'hFFFF0000; ty[6] = 32'h0000FFFF; tc[6] = 1'b1; te[6] = 33'h1_00000000;
        tx[7] = 32'hDEADBEEF; ty[7] = 32'h01010101; tc[7] = 1'b0; te[7] = 33'h0_DFAEBFF0;
    end

    bit mon_en = 1'b0;
    int rx     = 0;

    always @(negedge clk) begin
        if (mon_en && a_out_valid && a_out_ready) begin
            if (rx < 8) chk($sformatf("res%0d", rx), {a_cout, a_sum}, te[rx]);
            else        chk("extra_result", 1, 0);
            rx++;
        end
    end

    task automatic send32(input int i, output int tries);
        bit got = 1'b0;
        tries = 0;
        a_in_valid = 1'b1;
        a_x = tx[i]; a_y = ty[i]; a_cin = tc[i];
        while (!got && tries < 50) begin
            @(negedge clk);
            got = a_in_ready;
            @(posedge clk); #1;
            tries++;
        end
        if (!got) chk("send_timeout", 0, 1);
        a_in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int target);
        int n = 0;
        while (rx < target && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_count", rx, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, idx, cnt;
        rst = 1'b1;
        v8_in_valid = 0; v8_out_ready = 1; v8_x = 0; v8_y = 0; v8_cin = 0;
        a_in_valid = 0; a_out_ready = 1; a_x = 0; a_y = 0; a_cin = 0;
`ifdef ADDSUB_EN
        v8_sub = 0; a_sub = 0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_sum", a_sum, 0);
        chk("rst_cout", a_cout, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_in_ready8", v8_in_ready, 1);

        // 8-bit / 2-stage: two-edge latency
        @(posedge clk); #1;
        v8_x = 8'h6B; v8_y = 8'h5D; v8_cin = 0; v8_in_valid = 1;
        @(posedge clk); #1;
        v8_in_valid = 0;
        chk("u8_lat_ov", v8_out_valid, 0);
        @(posedge clk); #1;
        chk("u8_ov", v8_out_valid, 1);
        chk("u8_res", {v8_cout, v8_sum}, 9'h0C8);

        // 32-bit / 4-stage: full carry ripple, four-edge latency
        a_x = 32'hFFFFFFFF; a_y = 32'h0; a_cin = 1; a_in_valid = 1;
        @(posedge clk); #1;
        a_in_valid = 0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("u32_lat_ov", a_out_valid, 0);
        end
        @(posedge clk); #1;
        chk("u32_ov", a_out_valid, 1);
        chk("u32_wrap", {a_cout, a_sum}, 33'h1_00000000);
        @(posedge clk); #1;
        chk("u32_gone", a_out_valid, 0);

        // Back-to-back stream at one per clock
        rx = 0; mon_en = 1;
        for (int i = 0; i < 8; i++) begin
            send32(i, n);
            chk($sformatf("stream_rdy%0d", i), n, 1);
        end
        wait_rx(8);

        // Stall: exactly four accepted, outputs hold, then drain in order
        rx = 0; a_out_ready = 0; idx = 0;
        for (int c = 0; c < 8; c++) begin
            a_in_valid = 1; a_x = tx[idx]; a_y = ty[idx]; a_cin = tc[idx];
            @(negedge clk);
            if (a_in_ready) idx++;
            @(posedge clk); #1;
        end
        chk("stall_accepted", idx, 4);
        chk("stall_in_ready", a_in_ready, 0);
        chk("stall_ov", a_out_valid, 1);
        chk("stall_hold", {a_cout, a_sum}, te[0]);
        @(posedge clk); #1;
        chk("stall_hold2", {a_cout, a_sum}, te[0]);
        a_out_ready = 1;
        for (int i = 4; i < 8; i++) send32(i, n);
        wait_rx(8);

        // Reset with transactions in flight
        mon_en = 0; a_out_ready = 0;
        for (int i = 0; i < 3; i++) send32(i, n);
        @(posedge clk); #1;
        chk("pre_rst_ov", a_out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ov", a_out_valid, 0);
        chk("mid_rst_sum", a_sum, 0);
        chk("mid_rst_cout", a_cout, 0);
        @(posedge clk); #1;
        rst = 1'b0; a_out_ready = 1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_out_valid) cnt++;
        end
        chk("no_stale", cnt, 0);
        chk("post_rst_in_ready", a_in_ready, 1);

`ifdef ADDSUB_EN
        @(posedge clk); #1;
        v8_x = 8'h21; v8_y = 8'h40; v8_cin = 0; v8_sub = 1; v8_in_valid = 1;
        @(posedge clk); #1;
        v8_x = 8'h40; v8_y = 8'h11; v8_cin = 1; v8_sub = 1;
        @(posedge clk); #1;
        v8_in_valid = 0; v8_sub = 0;
        chk("sub_borrow", {v8_cout, v8_sum}, 9'h0E1);
        @(posedge clk); #1;
        chk("sub_noborrow", {v8_cout, v8_sum}, 9'h12E);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
